// File: rtl/fb_text_writer.sv
`default_nettype none
// ============================================================================
// Module   : fb_text_writer
// Purpose  : Terminal-style character writer for the 80x60 text frame buffer.
//            Places glyphs via read-modify-write of two-glyph memory words and
//            handles newline, carriage return, backspace, row clear on entry
//            and full-screen clear.
// Revision : 1.0 - initial release
// ============================================================================
module fb_text_writer #(
    parameter int                    ADDR_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] FB_START   = 'h3000,
    parameter int                    COLS       = 80,
    parameter int                    ROWS       = 60,
    parameter logic [7:0]            BLANK      = 8'h00
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  char_valid,
    input  logic [7:0]            char_data,
    output logic                  char_ready,
    output logic                  busy,
    output logic [6:0]            cursor_col,
    output logic [5:0]            cursor_row,
    output logic                  mem_req,
    input  logic                  mem_gnt,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [15:0]           mem_wdata,
    input  logic [15:0]           mem_rdata
);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_RD     = 3'd1;
    localparam logic [2:0] c_RWAIT  = 3'd2;
    localparam logic [2:0] c_WR     = 3'd3;
    localparam logic [2:0] c_ROWCLR = 3'd4;
    localparam logic [2:0] c_SCRCLR = 3'd5;

    localparam int          c_ROW_WORDS        = COLS / 2;
    localparam int          c_SCREEN_WORDS     = c_ROW_WORDS * ROWS;
    localparam logic [6:0]  c_LAST_COL         = 7'(COLS - 1);
    localparam logic [5:0]  c_LAST_ROW         = 6'(ROWS - 1);
    localparam logic [11:0] c_LAST_ROW_WORD    = 12'(c_ROW_WORDS - 1);
    localparam logic [11:0] c_LAST_SCREEN_WORD = 12'(c_SCREEN_WORDS - 1);

    localparam logic [7:0]  c_BS = 8'h08;
    localparam logic [7:0]  c_LF = 8'h0A;
    localparam logic [7:0]  c_FF = 8'h0C;
    localparam logic [7:0]  c_CR = 8'h0D;

    logic [2:0]            r_state, w_state_next;
    logic [6:0]            r_col, w_col_next;
    logic [5:0]            r_row, w_row_next;
    logic [7:0]            r_byte, w_byte_next;
    logic                  r_bs, w_bs_next;
    logic [11:0]           r_cnt, w_cnt_next;
    logic                  r_req, w_req_next;
    logic                  r_we, w_we_next;
    logic [ADDR_WIDTH-1:0] r_addr, w_addr_next;
    logic [15:0]           r_wdata, w_wdata_next;
    logic                  r_ready;
    logic                  r_busy;

    logic                  w_grant;
    logic                  w_accept;
    logic                  w_printable;
    logic [5:0]            w_row_adv;
    logic [15:0]           w_merged;

    // Word address of a glyph pair: base + row * words-per-row + col/2.
    function automatic logic [ADDR_WIDTH-1:0] f_word_addr(input logic [5:0] word_col,
                                                          input logic [5:0] row);
        f_word_addr = FB_START
                    + ADDR_WIDTH'(row) * ADDR_WIDTH'(c_ROW_WORDS)
                    + ADDR_WIDTH'(word_col);
    endfunction

    assign w_grant     = r_req & mem_gnt;
    assign w_accept    = (r_state == c_IDLE) & char_valid;
    assign w_printable = (char_data >= 8'h20);
    assign w_row_adv   = (r_row == c_LAST_ROW) ? 6'd0 : r_row + 6'd1;
    // Even column lives in the high byte, odd column in the low byte.
    assign w_merged    = r_col[0] ? {mem_rdata[15:8], r_byte} : {r_byte, mem_rdata[7:0]};

    // State register; reset aborts any operation in progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_accept) begin
                    if (w_printable) begin
                        w_state_next = c_RD;
                    end else if (char_data == c_LF) begin
                        w_state_next = c_ROWCLR;
                    end else if ((char_data == c_BS) && (r_col != 7'd0)) begin
                        w_state_next = c_RD;
                    end else if (char_data == c_FF) begin
                        w_state_next = c_SCRCLR;
                    end
                end
            end
            c_RD: begin
                if (w_grant) w_state_next = c_RWAIT;
            end
            c_RWAIT: begin
                w_state_next = c_WR;
            end
            c_WR: begin
                if (w_grant) begin
                    w_state_next = (!r_bs && (r_col == c_LAST_COL)) ? c_ROWCLR : c_IDLE;
                end
            end
            c_ROWCLR: begin
                if (w_grant && (r_cnt == c_LAST_ROW_WORD)) w_state_next = c_IDLE;
            end
            c_SCRCLR: begin
                if (w_grant && (r_cnt == c_LAST_SCREEN_WORD)) w_state_next = c_IDLE;
            end
            default: begin
                w_state_next = c_IDLE;
            end
        endcase
    end

    // Next values of cursor, latched byte and memory-port outputs.
    always_comb begin
        w_col_next   = r_col;
        w_row_next   = r_row;
        w_byte_next  = r_byte;
        w_bs_next    = r_bs;
        w_cnt_next   = r_cnt;
        w_req_next   = r_req;
        w_we_next    = r_we;
        w_addr_next  = r_addr;
        w_wdata_next = r_wdata;
        case (r_state)
            c_IDLE: begin
                if (w_accept) begin
                    w_byte_next = (char_data == c_BS) ? BLANK : char_data;
                    w_bs_next   = (char_data == c_BS);
                    if (w_printable) begin
                        w_req_next  = 1'b1;
                        w_we_next   = 1'b0;
                        w_addr_next = f_word_addr(r_col[6:1], r_row);
                    end else if (char_data == c_LF) begin
                        w_col_next   = 7'd0;
                        w_row_next   = w_row_adv;
                        w_req_next   = 1'b1;
                        w_we_next    = 1'b1;
                        w_addr_next  = f_word_addr(6'd0, w_row_adv);
                        w_wdata_next = {BLANK, BLANK};
                        w_cnt_next   = 12'd0;
                    end else if (char_data == c_CR) begin
                        w_col_next = 7'd0;
                    end else if ((char_data == c_BS) && (r_col != 7'd0)) begin
                        w_col_next  = r_col - 7'd1;
                        w_req_next  = 1'b1;
                        w_we_next   = 1'b0;
                        w_addr_next = f_word_addr(w_col_next[6:1], r_row);
                    end else if (char_data == c_FF) begin
                        w_req_next   = 1'b1;
                        w_we_next    = 1'b1;
                        w_addr_next  = FB_START;
                        w_wdata_next = {BLANK, BLANK};
                        w_cnt_next   = 12'd0;
                    end
                end
            end
            c_RD: begin
                if (w_grant) w_req_next = 1'b0;
            end
            c_RWAIT: begin
                w_req_next   = 1'b1;
                w_we_next    = 1'b1;
                w_wdata_next = w_merged;
            end
            c_WR: begin
                if (w_grant) begin
                    if (r_bs) begin
                        w_req_next = 1'b0;
                        w_we_next  = 1'b0;
                    end else if (r_col != c_LAST_COL) begin
                        w_col_next = r_col + 7'd1;
                        w_req_next = 1'b0;
                        w_we_next  = 1'b0;
                    end else begin
                        w_col_next   = 7'd0;
                        w_row_next   = w_row_adv;
                        w_addr_next  = f_word_addr(6'd0, w_row_adv);
                        w_wdata_next = {BLANK, BLANK};
                        w_cnt_next   = 12'd0;
                    end
                end
            end
            c_ROWCLR: begin
                if (w_grant) begin
                    if (r_cnt == c_LAST_ROW_WORD) begin
                        w_req_next = 1'b0;
                        w_we_next  = 1'b0;
                    end else begin
                        w_cnt_next  = r_cnt + 12'd1;
                        w_addr_next = r_addr + 1'b1;
                    end
                end
            end
            c_SCRCLR: begin
                if (w_grant) begin
                    if (r_cnt == c_LAST_SCREEN_WORD) begin
                        w_req_next = 1'b0;
                        w_we_next  = 1'b0;
                        w_col_next = 7'd0;
                        w_row_next = 6'd0;
                    end else begin
                        w_cnt_next  = r_cnt + 12'd1;
                        w_addr_next = r_addr + 1'b1;
                    end
                end
            end
            default: begin
                w_req_next = 1'b0;
                w_we_next  = 1'b0;
            end
        endcase
    end

    // Output and datapath registers; handshake flags follow the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_col   <= 7'd0;
            r_row   <= 6'd0;
            r_byte  <= 8'd0;
            r_bs    <= 1'b0;
            r_cnt   <= 12'd0;
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= FB_START;
            r_wdata <= 16'd0;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
        end else begin
            r_col   <= w_col_next;
            r_row   <= w_row_next;
            r_byte  <= w_byte_next;
            r_bs    <= w_bs_next;
            r_cnt   <= w_cnt_next;
            r_req   <= w_req_next;
            r_we    <= w_we_next;
            r_addr  <= w_addr_next;
            r_wdata <= w_wdata_next;
            r_ready <= (w_state_next == c_IDLE);
            r_busy  <= (w_state_next != c_IDLE);
        end
    end

    assign char_ready = r_ready;
    assign busy       = r_busy;
    assign cursor_col = r_col;
    assign cursor_row = r_row;
    assign mem_req    = r_req;
    assign mem_we     = r_we;
    assign mem_addr   = r_addr;
    assign mem_wdata  = r_wdata;

endmodule
`default_nettype wire
